ag32gbd_sram_arb: RTL and testbench

Arbiter and sequencer for the cartridge's external save SRAM. It is shared between three requesters: the Game Boy cartridge bus, the internal image writer (camera pipeline copying finished blocks into SRAM), and an internal reader (AHB readback/debug). Cartridge accesses always win. The two internal requesters are served round-robin with fixed-length strobe sequences. The block sits between the cartridge RAM decode and the SRAM pins, replacing direct pin drive.

---
 rtl/ag32gbd_sram_arb.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ag32gbd_sram_arb.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_sram_arb.sv
// ---------------------------------------------------------------------------
// ag32gbd_sram_arb
//
// Arbiter and strobe sequencer for the cartridge's external save SRAM.
// Three requesters share the SRAM pins:
//   - the Game Boy cartridge bus (always wins, never preempted)
//   - the internal image writer (wr_* port)
//   - the internal readback/debug reader (rd_* port)
// The two internal requesters are served round-robin. Each internal access
// is a fixed strobe sequence of HOLD_CYCLES active cycles. Every access,
// cart or internal, is followed by TURN_CYCLES of bus turnaround with all
// strobes high and DQ released.
//
// Parameters:
//   ADDR_W       SRAM address width
//   HOLD_CYCLES  cycles nWE/nRD are held low for an internal access (>=1)
//   TURN_CYCLES  idle cycles after every access (>=1)
//
// Ports:
//   sys_clock, sys_reset       sole clock, asynchronous active-high reset
//   cart_sel                   cart SRAM window active (asynchronous input)
//   cart_wr/addr/wdata         cart access direction, address, write data
//   cart_rdata, cart_active    last byte read for cart, arbiter in CART
//   wr_req/addr/data, wr_ack   internal write request and completion pulse
//   rd_req/addr, rd_data/valid internal read request and result pulse
//   sram_a, sram_dq_o/oe/i     SRAM address and data bus
//   sram_ncs/nwe/nrd           active-low SRAM strobes
//
// Optional feature (macro AG32GBD_SRAM_ARB_STATS_EN):
//   adds output stall_cnt[15:0], a saturating count of cycles in which the
//   synchronized cart_sel is high while the arbiter is not in CART.
// ---------------------------------------------------------------------------
module ag32gbd_sram_arb #(
   parameter int ADDR_W      = 17,
   parameter int HOLD_CYCLES = 2,
   parameter int TURN_CYCLES = 1
) (
   input  logic              sys_clock,
   input  logic              sys_reset,
   input  logic              cart_sel,
   input  logic              cart_wr,
   input  logic [ADDR_W-1:0] cart_addr,
   input  logic [7:0]        cart_wdata,
   output logic [7:0]        cart_rdata,
   output logic              cart_active,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] sram_a,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_i,
   output logic              sram_ncs,
   output logic              sram_nwe,
`ifdef AG32GBD_SRAM_ARB_STATS_EN
   output logic              sram_nrd,
   output logic [15:0]       stall_cnt
`else
   output logic              sram_nrd
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      CART,
      IWR,
      IRD,
      RECOVER
   } state_t;

   // One shared phase counter serves both the hold and the turnaround
   // phases, so it is sized for whichever of the two is longer.
   localparam int MAX_CYC = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] phase_cnt;
   logic             favour_wr;
   logic             cart_sel_meta;
   logic             cart_sel_sync;

   // cart_sel comes from the Game Boy bus and is asynchronous to sys_clock.
   // Two flops bring it into this domain; only the second stage is ever
   // used for decisions. The cart address/data are not synchronized: the
   // cart holds them stable for the whole window, long after cart_sel has
   // passed through the synchronizer.
   always_ff @(posedge sys_clock or posedge sys_reset) begin
      if (sys_reset) begin
         cart_sel_meta <= 1'b0;
         cart_sel_sync <= 1'b0;
      end else begin
         cart_sel_meta <= cart_sel;
         cart_sel_sync <= cart_sel_meta;
      end
   end

   // Main arbiter/sequencer. Every pin-facing output is a register set here
   // on the transition into each phase, so the SRAM sees glitch-free strobes.
   //
   // phase_cnt holds the 1-based index of the cycle currently being shown on
   // the pins; it is loaded with 1 on the edge that enters a timed phase and
   // the phase ends on the edge where it equals the phase length.
   //
   // Grant priority in IDLE: synchronized cart first, then the internal
   // requester that was not granted last when both are pending. favour_wr
   // records which internal requester gets the next tie.
   //
   // The read data is captured on the edge that ends the last hold cycle,
   // which is also the edge that raises rd_valid, so rd_valid appears in the
   // cycle after the last hold cycle together with the fresh rd_data.
   //
   // The cart direction drives sram_nrd and sram_dq_oe from the same input
   // bit, so DQ is never driven while the SRAM output enable is active.
   always_ff @(posedge sys_clock or posedge sys_reset) begin
      if (sys_reset) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         favour_wr   <= 1'b1;
         sram_a      <= '0;
         sram_dq_o   <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ncs    <= 1'b1;
         sram_nwe    <= 1'b1;
         sram_nrd    <= 1'b1;
         cart_rdata  <= '0;
         cart_active <= 1'b0;
         rd_data     <= '0;
         wr_ack      <= 1'b0;
         rd_valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_ack   <= 1'b0;
               rd_valid <= 1'b0;
               if (cart_sel_sync) begin
                  state       <= CART;
                  cart_active <= 1'b1;
                  sram_a      <= cart_addr;
                  sram_dq_o   <= cart_wdata;
                  sram_ncs    <= 1'b0;
                  sram_nwe    <= ~cart_wr;
                  sram_nrd    <= cart_wr;
                  sram_dq_oe  <= cart_wr;
               end else if (wr_req && (!rd_req || favour_wr)) begin
                  state      <= IWR;
                  phase_cnt  <= CNT_ONE;
                  favour_wr  <= 1'b0;
                  sram_a     <= wr_addr;
                  sram_dq_o  <= wr_data;
                  sram_ncs   <= 1'b0;
                  sram_nwe   <= 1'b0;
                  sram_nrd   <= 1'b1;
                  sram_dq_oe <= 1'b1;
                  wr_ack     <= (HOLD_CYCLES == 1);
               end else if (rd_req) begin
                  state      <= IRD;
                  phase_cnt  <= CNT_ONE;
                  favour_wr  <= 1'b1;
                  sram_a     <= rd_addr;
                  sram_ncs   <= 1'b0;
                  sram_nwe   <= 1'b1;
                  sram_nrd   <= 1'b0;
                  sram_dq_oe <= 1'b0;
               end
            end

            CART: begin
               if (!cart_wr) begin
                  cart_rdata <= sram_dq_i;
               end
               if (!cart_sel_sync) begin
                  state       <= RECOVER;
                  phase_cnt   <= CNT_ONE;
                  cart_active <= 1'b0;
                  sram_ncs    <= 1'b1;
                  sram_nwe    <= 1'b1;
                  sram_nrd    <= 1'b1;
                  sram_dq_oe  <= 1'b0;
               end else begin
                  sram_a     <= cart_addr;
                  sram_dq_o  <= cart_wdata;
                  sram_ncs   <= 1'b0;
                  sram_nwe   <= ~cart_wr;
                  sram_nrd   <= cart_wr;
                  sram_dq_oe <= cart_wr;
               end
            end

            IWR: begin
               if (phase_cnt == HOLD_LAST) begin
                  state      <= RECOVER;
                  phase_cnt  <= CNT_ONE;
                  wr_ack     <= 1'b0;
                  sram_ncs   <= 1'b1;
                  sram_nwe   <= 1'b1;
                  sram_nrd   <= 1'b1;
                  sram_dq_oe <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt + CNT_ONE;
                  wr_ack    <= (phase_cnt + CNT_ONE == HOLD_LAST);
               end
            end

            IRD: begin
               if (phase_cnt == HOLD_LAST) begin
                  state      <= RECOVER;
                  phase_cnt  <= CNT_ONE;
                  rd_data    <= sram_dq_i;
                  rd_valid   <= 1'b1;
                  sram_ncs   <= 1'b1;
                  sram_nwe   <= 1'b1;
                  sram_nrd   <= 1'b1;
                  sram_dq_oe <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt + CNT_ONE;
               end
            end

            RECOVER: begin
               wr_ack   <= 1'b0;
               rd_valid <= 1'b0;
               if (phase_cnt == TURN_LAST) begin
                  state <= IDLE;
               end else begin
                  phase_cnt <= phase_cnt + CNT_ONE;
               end
            end

            default: begin
               state       <= IDLE;
               cart_active <= 1'b0;
               wr_ack      <= 1'b0;
               rd_valid    <= 1'b0;
               sram_ncs    <= 1'b1;
               sram_nwe    <= 1'b1;
               sram_nrd    <= 1'b1;
               sram_dq_oe  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AG32GBD_SRAM_ARB_STATS_EN
   // Cart stall statistics: counts cycles in which the cart has (as seen
   // through the synchronizer) asked for the SRAM but does not yet own it.
   // The counter sticks at all-ones rather than wrapping so a long soak run
   // never reports a misleadingly small value.
   always_ff @(posedge sys_clock or posedge sys_reset) begin
      if (sys_reset) begin
         stall_cnt <= '0;
      end else if (cart_sel_sync && (state != CART) && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ag32gbd_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_ag32gbd_sram_arb
//
// Self-checking bench for ag32gbd_sram_arb. A reference model tracks the
// arbiter as a synchronizer delay line plus a queue of planned per-cycle pin
// values: when an access is granted, its whole strobe sequence (hold cycles,
// turnaround, idle decision cycle) is pushed into the plan at once, and the
// model simply pops one entry per clock. Directed scenarios are followed by
// a randomized soak with an asynchronous reset in the middle.
// ---------------------------------------------------------------------------
module tb_ag32gbd_sram_arb;

   localparam int ADDR_W = 17;
   localparam int HOLD   = 2;
   localparam int TURN   = 1;

   logic              sys_clock = 1'b0;
   logic              sys_reset;
   logic              cart_sel;
   logic              cart_wr;
   logic [ADDR_W-1:0] cart_addr;
   logic [7:0]        cart_wdata;
   logic [7:0]        cart_rdata;
   logic              cart_active;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] sram_a;
   logic [7:0]        sram_dq_o;
   logic              sram_dq_oe;
   logic [7:0]        sram_dq_i;
   logic              sram_ncs;
   logic              sram_nwe;
   logic              sram_nrd;
`ifdef AG32GBD_SRAM_ARB_STATS_EN
   logic [15:0]       stall_cnt;
`endif

   ag32gbd_sram_arb #(
      .ADDR_W      (ADDR_W),
      .HOLD_CYCLES (HOLD),
      .TURN_CYCLES (TURN)
   ) dut (
      .sys_clock   (sys_clock),
      .sys_reset   (sys_reset),
      .cart_sel    (cart_sel),
      .cart_wr     (cart_wr),
      .cart_addr   (cart_addr),
      .cart_wdata  (cart_wdata),
      .cart_rdata  (cart_rdata),
      .cart_active (cart_active),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .sram_a      (sram_a),
      .sram_dq_o   (sram_dq_o),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_i   (sram_dq_i),
      .sram_ncs    (sram_ncs),
      .sram_nwe    (sram_nwe),
`ifdef AG32GBD_SRAM_ARB_STATS_EN
      .sram_nrd    (sram_nrd),
      .stall_cnt   (stall_cnt)
`else
      .sram_nrd    (sram_nrd)
`endif
   );

   // 100 MHz system clock.
   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic              ncs;
      logic              nwe;
      logic              nrd;
      logic              oe;
      logic              ack;
      logic              valid;
      logic [ADDR_W-1:0] a;
      logic [7:0]        dq;
   } pins_t;

   pins_t       plan[$];
   pins_t       cur;
   bit          sel_hist[$];
   bit          m_in_cart;
   bit          m_favour_wr;
   logic [7:0]  exp_cart_rdata;
   logic [7:0]  exp_rd_data;
   logic [15:0] exp_stall;

   int          checks;
   int          failures;
   byte         dut_log[$];
   bit          prev_ncs;
   bit          wr_repeat;
   bit          rd_repeat;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic pins_t idlePins();
      pins_t p;
      p.ncs   = 1'b1;
      p.nwe   = 1'b1;
      p.nrd   = 1'b1;
      p.oe    = 1'b0;
      p.ack   = 1'b0;
      p.valid = 1'b0;
      p.a     = '0;
      p.dq    = '0;
      return p;
   endfunction

   function automatic pins_t cartPins();
      pins_t p;
      p     = idlePins();
      p.ncs = 1'b0;
      p.nwe = ~cart_wr;
      p.nrd = cart_wr;
      p.oe  = cart_wr;
      p.a   = cart_addr;
      p.dq  = cart_wdata;
      return p;
   endfunction

   // Turnaround cycles plus the idle cycle in which the next grant is made.
   task automatic queueTail(input bit with_valid);
      pins_t p;
      for (int t = 0; t <= TURN; t++) begin
         p       = idlePins();
         p.valid = with_valid && (t == 0);
         plan.push_back(p);
      end
   endtask

   task automatic modelReset();
      plan.delete();
      sel_hist.delete();
      sel_hist.push_back(1'b0);
      sel_hist.push_back(1'b0);
      m_in_cart      = 1'b0;
      m_favour_wr    = 1'b1;
      exp_cart_rdata = '0;
      exp_rd_data    = '0;
      exp_stall      = '0;
      cur            = idlePins();
   endtask

   // Advances the model by one clock edge using the inputs present at it.
   task automatic modelStep();
      bit    synced;
      pins_t p;
      if (sys_reset) begin
         modelReset();
         return;
      end
      synced = sel_hist.pop_front();
      sel_hist.push_back(cart_sel);
      if (synced && !m_in_cart && exp_stall != 16'hFFFF) exp_stall++;
      if (m_in_cart && !cart_wr) exp_cart_rdata = sram_dq_i;
      if (plan.size() > 0) begin
         cur = plan.pop_front();
         if (cur.valid) exp_rd_data = sram_dq_i;
      end else if (m_in_cart) begin
         if (synced) begin
            cur = cartPins();
         end else begin
            m_in_cart = 1'b0;
            queueTail(1'b0);
            cur = plan.pop_front();
         end
      end else if (synced) begin
         m_in_cart = 1'b1;
         cur       = cartPins();
      end else if (wr_req && (!rd_req || m_favour_wr)) begin
         m_favour_wr = 1'b0;
         for (int h = 1; h <= HOLD; h++) begin
            p     = idlePins();
            p.ncs = 1'b0;
            p.nwe = 1'b0;
            p.oe  = 1'b1;
            p.a   = wr_addr;
            p.dq  = wr_data;
            p.ack = (h == HOLD);
            plan.push_back(p);
         end
         queueTail(1'b0);
         cur = plan.pop_front();
      end else if (rd_req) begin
         m_favour_wr = 1'b1;
         for (int h = 1; h <= HOLD; h++) begin
            p     = idlePins();
            p.ncs = 1'b0;
            p.nrd = 1'b0;
            p.a   = rd_addr;
            plan.push_back(p);
         end
         queueTail(1'b1);
         cur = plan.pop_front();
      end else begin
         cur = idlePins();
      end
   endtask

   task automatic compareAll();
      checkOutput("ncs", sram_ncs, cur.ncs);
      checkOutput("nwe", sram_nwe, cur.nwe);
      checkOutput("nrd", sram_nrd, cur.nrd);
      checkOutput("dq_oe", sram_dq_oe, cur.oe);
      checkOutput("wr_ack", wr_ack, cur.ack);
      checkOutput("rd_valid", rd_valid, cur.valid);
      checkOutput("cart_active", cart_active, m_in_cart);
      checkOutput("cart_rdata", cart_rdata, exp_cart_rdata);
      checkOutput("rd_data", rd_data, exp_rd_data);
      if (!cur.ncs) checkOutput("sram_a", sram_a, cur.a);
      if (cur.oe) checkOutput("dq_o", sram_dq_o, cur.dq);
`ifdef AG32GBD_SRAM_ARB_STATS_EN
      checkOutput("stall_cnt", stall_cnt, exp_stall);
`endif
      if (!sram_ncs && prev_ncs) begin
         if (cart_active) dut_log.push_back("C");
         else if (!sram_nwe) dut_log.push_back("W");
         else dut_log.push_back("R");
      end
      prev_ncs = sram_ncs;
   endtask

   // One clock: model and DUT advance on the edge, outputs compared 1ns later.
   task automatic applyStimulus();
      @(posedge sys_clock);
      modelStep();
      #1;
      compareAll();
   endtask

   // Requester-side protocol: drop (or renew) a request once it completes.
   task automatic serviceRequesters();
      if (wr_ack) begin
         if (wr_repeat) begin
            wr_addr = ADDR_W'($urandom);
            wr_data = 8'($urandom);
         end else begin
            wr_req = 1'b0;
         end
      end
      if (rd_valid) begin
         if (rd_repeat) rd_addr = ADDR_W'($urandom);
         else rd_req = 1'b0;
      end
   endtask

   task automatic pulseReset();
      sys_reset = 1'b1;
      modelReset();
      repeat (2) applyStimulus();
      sys_reset = 1'b0;
   endtask

   initial begin
      int          hold_seen;
      int          ack_at;
      int          nrd_low;
      int          last_nrd;
      int          valid_at;
      int          lat;
      int          starved;
      int          waited;
      bit          got;
      int          cart_timer;
      logic [15:0] stall0;
      logic [31:0] order;

      checks     = 0;
      failures   = 0;
      sys_reset  = 1'b1;
      cart_sel   = 1'b0;
      cart_wr    = 1'b0;
      cart_addr  = '0;
      cart_wdata = '0;
      wr_req     = 1'b1;
      wr_addr    = 17'h00123;
      wr_data    = 8'hA5;
      rd_req     = 1'b0;
      rd_addr    = '0;
      sram_dq_i  = '0;
      wr_repeat  = 1'b0;
      rd_repeat  = 1'b0;
      prev_ncs   = 1'b1;
      stall0     = '0;
      modelReset();

      // Reset held with a write pending: pins stay idle, no ack.
      repeat (3) applyStimulus();
      checkOutput("reset_sram_a", sram_a, 0);
      checkOutput("reset_dq_o", sram_dq_o, 0);
      checkOutput("reset_wr_ack", wr_ack, 0);
      sys_reset = 1'b0;

      // Write 0x00123/0xA5 starts one cycle after release.
      applyStimulus();
      checkOutput("iwr_after_release", sram_nwe, 0);
      hold_seen = (!sram_nwe && sram_a == 17'h00123 && sram_dq_o == 8'hA5 && sram_dq_oe) ? 1 : 0;
      ack_at    = wr_ack ? 1 : 0;
      serviceRequesters();
      for (int i = 2; i <= 8; i++) begin
         applyStimulus();
         if (!sram_nwe && sram_a == 17'h00123 && sram_dq_o == 8'hA5 && sram_dq_oe) hold_seen++;
         if (wr_ack) ack_at = i;
         serviceRequesters();
      end
      checkOutput("wr_hold_cycles", hold_seen, HOLD);
      checkOutput("wr_ack_cycle", ack_at, HOLD);

      // Read 0x1FFFF returning 0x3C.
      rd_req    = 1'b1;
      rd_addr   = 17'h1FFFF;
      sram_dq_i = 8'h3C;
      nrd_low   = 0;
      last_nrd  = 0;
      valid_at  = 0;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus();
         if (!sram_nrd && sram_a == 17'h1FFFF) begin
            nrd_low++;
            last_nrd = i;
         end
         if (rd_valid) begin
            valid_at = i;
            checkOutput("rd_data_3c", rd_data, 8'h3C);
         end
         serviceRequesters();
      end
      checkOutput("rd_hold_cycles", nrd_low, HOLD);
      checkOutput("rd_valid_next_cycle", valid_at, last_nrd + 1);

      // Both internal requesters held: grants alternate starting with wr.
      pulseReset();
      wr_repeat = 1'b1;
      rd_repeat = 1'b1;
      wr_req    = 1'b1;
      rd_req    = 1'b1;
      dut_log.delete();
      repeat (20) begin
         applyStimulus();
         serviceRequesters();
      end
      wr_repeat = 1'b0;
      rd_repeat = 1'b0;
      repeat (12) begin
         applyStimulus();
         serviceRequesters();
      end
      checkOutput("grant_count", dut_log.size() >= 4, 1);
      order = {dut_log[0], dut_log[1], dut_log[2], dut_log[3]};
      checkOutput("grant_order", order, "WRWR");

      // Reset mid-write: strobes release at once, write restarts after release.
      wr_req  = 1'b1;
      wr_addr = ADDR_W'($urandom);
      wr_data = 8'($urandom);
      for (int i = 0; i < 10 && sram_nwe; i++) applyStimulus();
      checkOutput("iwr_started", sram_nwe, 0);
      sys_reset = 1'b1;
      #1;
      checkOutput("async_ncs", sram_ncs, 1);
      checkOutput("async_nwe", sram_nwe, 1);
      checkOutput("async_dq_oe", sram_dq_oe, 0);
      modelReset();
      repeat (2) applyStimulus();
      sys_reset = 1'b0;
      applyStimulus();
      checkOutput("iwr_restart", sram_nwe, 0);
      repeat (6) begin
         applyStimulus();
         serviceRequesters();
      end

      // Cart arrives in the first write hold cycle.
      wr_req  = 1'b1;
      wr_addr = ADDR_W'($urandom);
      wr_data = 8'($urandom);
      for (int i = 0; i < 10 && sram_nwe; i++) begin
         applyStimulus();
         serviceRequesters();
      end
      cart_sel  = 1'b1;
      cart_wr   = 1'b0;
      cart_addr = ADDR_W'($urandom);
      sram_dq_i = 8'h5A;
`ifdef AG32GBD_SRAM_ARB_STATS_EN
      stall0 = stall_cnt;
`endif
      lat = 0;
      while (!cart_active && lat < 20) begin
         applyStimulus();
         serviceRequesters();
         lat++;
      end
      checkOutput("cart_granted", cart_active, 1);
      checkOutput("cart_latency_le6", lat <= 6, 1);
      checkOutput("iwr_completed", wr_req, 0);
`ifdef AG32GBD_SRAM_ARB_STATS_EN
      checkOutput("stall_measured", stall_cnt - stall0, 16'(lat - 2));
`endif
      repeat (3) applyStimulus();
      checkOutput("cart_rdata_5a", cart_rdata, 8'h5A);

      // Cart held 100 cycles with a read pending: the read starves.
      rd_req  = 1'b1;
      rd_addr = ADDR_W'($urandom);
      starved = 0;
      repeat (100) begin
         applyStimulus();
         if (!sram_nrd && !cart_active) starved++;
         serviceRequesters();
      end
      checkOutput("no_ird_during_cart", starved, 0);
      cart_sel = 1'b0;
      waited   = 0;
      got      = 1'b0;
      while (!got && waited < 20) begin
         applyStimulus();
         waited++;
         if (rd_valid) got = 1'b1;
         serviceRequesters();
      end
      checkOutput("ird_after_cart", got, 1);
      checkOutput("ird_wait_cycles", waited, 3 + TURN + 1 + HOLD);

      // Randomized soak with one reset in the middle.
      cart_timer = 20;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) pulseReset();
         applyStimulus();
         serviceRequesters();
         if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req  = 1'b1;
            wr_addr = ADDR_W'($urandom);
            wr_data = 8'($urandom);
         end
         if (!rd_req && $urandom_range(0, 3) == 0) begin
            rd_req  = 1'b1;
            rd_addr = ADDR_W'($urandom);
         end
         if (cart_timer == 0) begin
            cart_sel   = ~cart_sel;
            cart_timer = cart_sel ? $urandom_range(2, 20) : $urandom_range(5, 60);
         end else begin
            cart_timer--;
         end
         cart_wr    = 1'($urandom);
         cart_addr  = ADDR_W'($urandom);
         cart_wdata = 8'($urandom);
         sram_dq_i  = 8'($urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
